// File: rtl/iir_stereo_sched.sv
// Stereo first-order IIR (de-emphasis) sharing one multiply/dequantize/accumulate
// engine between the left and right channels under round-robin scheduling.
module iir_stereo_sched #(
  parameter int unsigned          DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] B0        = 32'h000000B2,
  parameter logic [DATA_SIZE-1:0] B1        = 32'h000000B2,
  parameter logic [DATA_SIZE-1:0] A1        = 32'hFFFFFD66
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] l_din,
  input  logic                 l_empty,
  output logic                 l_rd_en,
  input  logic [DATA_SIZE-1:0] r_din,
  input  logic                 r_empty,
  output logic                 r_rd_en,
  output logic [DATA_SIZE-1:0] l_dout,
  input  logic                 l_full,
  output logic                 l_wr_en,
  output logic [DATA_SIZE-1:0] r_dout,
  input  logic                 r_full,
  output logic                 r_wr_en,
  input  logic                 clear,
  output logic                 busy
);

  localparam int unsigned FRAC_BITS = 10;
  localparam int unsigned PROD_W    = 2 * DATA_SIZE;
  localparam logic        CH_L      = 1'b0;
  localparam logic        CH_R      = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC0  = 3'd1,
    S_MAC1  = 3'd2,
    S_MAC2  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   last_grant_q, last_grant_d;
  logic                   clr_pend_q, clr_pend_d;
  logic [DATA_SIZE-1:0]   xcur_q, xcur_d;
  logic [DATA_SIZE-1:0]   acc_q, acc_d;
  logic [DATA_SIZE-1:0]   xl1_q, xl1_d, yl1_q, yl1_d;
  logic [DATA_SIZE-1:0]   xr1_q, xr1_d, yr1_q, yr1_d;
  logic [DATA_SIZE-1:0]   l_dout_q, l_dout_d, r_dout_q, r_dout_d;
  logic                   l_wr_en_q, l_wr_en_d, r_wr_en_q, r_wr_en_d;

  logic                   grant_l, grant_r;
  logic                   l_elig, r_elig, sel_full, clr_eff;
  logic signed [DATA_SIZE-1:0] coef_s, data_s;
  logic signed [PROD_W-1:0]    prod;
  logic [DATA_SIZE-1:0]   deq_res;

  // Fixed-point rescale that truncates toward zero for both signs.
  function automatic logic [DATA_SIZE-1:0] deq(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] q;
    if (p < 0) q = -((-p) >>> FRAC_BITS);
    else       q = p >>> FRAC_BITS;
    return q[DATA_SIZE-1:0];
  endfunction

  // Operand select for the single shared multiplier.
  always_comb begin
    coef_s = $signed(B0);
    data_s = $signed(xcur_q);
    unique case (state_q)
      S_MAC1: begin
        coef_s = $signed(B1);
        data_s = $signed((sel_q == CH_R) ? xr1_q : xl1_q);
      end
      S_MAC2: begin
        coef_s = $signed(A1);
        data_s = $signed((sel_q == CH_R) ? yr1_q : yl1_q);
      end
      default: ;
    endcase
  end

  assign prod    = PROD_W'(coef_s) * PROD_W'(data_s);
  assign deq_res = deq(prod);

  assign l_elig   = !l_empty && !l_full;
  assign r_elig   = !r_empty && !r_full;
  assign sel_full = (sel_q == CH_R) ? r_full : l_full;
  assign clr_eff  = clr_pend_q || clear;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    clr_pend_d   = clr_pend_q;
    xcur_d       = xcur_q;
    acc_d        = acc_q;
    xl1_d        = xl1_q;
    yl1_d        = yl1_q;
    xr1_d        = xr1_q;
    yr1_d        = yr1_q;
    l_dout_d     = l_dout_q;
    r_dout_d     = r_dout_q;
    l_wr_en_d    = 1'b0;
    r_wr_en_d    = 1'b0;
    grant_l      = 1'b0;
    grant_r      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          xl1_d = '0;
          yl1_d = '0;
          xr1_d = '0;
          yr1_d = '0;
        end else if (l_elig && (!r_elig || last_grant_q == CH_R)) begin
          grant_l = 1'b1;
        end else if (r_elig) begin
          grant_r = 1'b1;
        end
        if (grant_l || grant_r) begin
          sel_d        = grant_r;
          last_grant_d = grant_r;
          xcur_d       = grant_r ? r_din : l_din;
          acc_d        = '0;
          clr_pend_d   = 1'b0;
          state_d      = S_MAC0;
        end
      end
      S_MAC0: begin
        acc_d      = acc_q + deq_res;
        clr_pend_d = clr_eff;
        state_d    = S_MAC1;
      end
      S_MAC1: begin
        acc_d      = acc_q + deq_res;
        clr_pend_d = clr_eff;
        state_d    = S_MAC2;
      end
      S_MAC2: begin
        acc_d      = acc_q - deq_res;
        clr_pend_d = clr_eff;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        clr_pend_d = clr_eff;
        if (!sel_full) begin
          // A clear seen during the sample zeroes the write-back instead of updating it.
          if (sel_q == CH_R) begin
            r_dout_d  = acc_q;
            r_wr_en_d = 1'b1;
            xr1_d     = clr_eff ? '0 : xcur_q;
            yr1_d     = clr_eff ? '0 : acc_q;
          end else begin
            l_dout_d  = acc_q;
            l_wr_en_d = 1'b1;
            xl1_d     = clr_eff ? '0 : xcur_q;
            yl1_d     = clr_eff ? '0 : acc_q;
          end
          clr_pend_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= CH_L;
      last_grant_q <= CH_R;
      clr_pend_q   <= 1'b0;
      xcur_q       <= '0;
      acc_q        <= '0;
      xl1_q        <= '0;
      yl1_q        <= '0;
      xr1_q        <= '0;
      yr1_q        <= '0;
      l_dout_q     <= '0;
      r_dout_q     <= '0;
      l_wr_en_q    <= 1'b0;
      r_wr_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      clr_pend_q   <= clr_pend_d;
      xcur_q       <= xcur_d;
      acc_q        <= acc_d;
      xl1_q        <= xl1_d;
      yl1_q        <= yl1_d;
      xr1_q        <= xr1_d;
      yr1_q        <= yr1_d;
      l_dout_q     <= l_dout_d;
      r_dout_q     <= r_dout_d;
      l_wr_en_q    <= l_wr_en_d;
      r_wr_en_q    <= r_wr_en_d;
    end
  end

  // Pops are held off while reset is asserted so every output reads 0 during reset.
  assign l_rd_en = grant_l && !reset;
  assign r_rd_en = grant_r && !reset;
  assign l_dout  = l_dout_q;
  assign r_dout  = r_dout_q;
  assign l_wr_en = l_wr_en_q;
  assign r_wr_en = r_wr_en_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_iir_stereo_sched.sv
// Self-checking bench for iir_stereo_sched: FIFO models on both sides and an
// arithmetic per-channel IIR reference model.
module tb_iir_stereo_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] l_din = '0, r_din = '0;
  logic        l_empty = 1'b1, r_empty = 1'b1;
  logic        l_full = 1'b0, r_full = 1'b0, clear = 1'b0;
  logic        l_rd_en, r_rd_en, l_wr_en, r_wr_en, busy;
  logic [31:0] l_dout, r_dout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lq[$], rq[$], exp_l[$], exp_r[$];
  int got_l[$], got_r[$], got_l_cyc[$], got_r_cyc[$], g_ch[$], g_cyc[$];
  bit l_pop = 0, r_pop = 0;
  int xm[2], ym[2];

  iir_stereo_sched dut (
    .clock(clock), .reset(reset),
    .l_din(l_din), .l_empty(l_empty), .l_rd_en(l_rd_en),
    .r_din(r_din), .r_empty(r_empty), .r_rd_en(r_rd_en),
    .l_dout(l_dout), .l_full(l_full), .l_wr_en(l_wr_en),
    .r_dout(r_dout), .r_full(r_full), .r_wr_en(r_wr_en),
    .clear(clear), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: integer division truncates toward zero, int sums wrap.
  function automatic int deqm(longint p);
    longint q;
    q = p / 64'sd1024;
    return int'(q);
  endfunction

  function automatic int model_step(int ch, int x);
    int y;
    y = deqm(longint'(178) * longint'(x)) + deqm(longint'(178) * longint'(xm[ch]))
        - deqm(longint'(-666) * longint'(ym[ch]));
    xm[ch] = x;
    ym[ch] = y;
    return y;
  endfunction

  function automatic void refresh();
    l_empty = (lq.size() == 0);
    r_empty = (rq.size() == 0);
    l_din   = (lq.size() > 0) ? 32'(lq[0]) : 32'd0;
    r_din   = (rq.size() > 0) ? 32'(rq[0]) : 32'd0;
  endfunction

  // Monitor: strobes sampled on the falling edge.
  always @(negedge clock) begin
    l_pop = l_rd_en;
    r_pop = r_rd_en;
    if (l_rd_en) begin g_ch.push_back(0); g_cyc.push_back(cyc); end
    if (r_rd_en) begin g_ch.push_back(1); g_cyc.push_back(cyc); end
    if (l_wr_en) begin got_l.push_back(int'(l_dout)); got_l_cyc.push_back(cyc); end
    if (r_wr_en) begin got_r.push_back(int'(r_dout)); got_r_cyc.push_back(cyc); end
  end

  // Input FIFO models: pop after the edge that consumed the head.
  always @(posedge clock) begin
    cyc = cyc + 1;
    #1;
    if (l_pop && lq.size() > 0) void'(lq.pop_front());
    if (r_pop && rq.size() > 0) void'(rq.pop_front());
    l_pop = 0;
    r_pop = 0;
    refresh();
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic clear_logs();
    lq.delete(); rq.delete(); exp_l.delete(); exp_r.delete();
    got_l.delete(); got_r.delete(); got_l_cyc.delete(); got_r_cyc.delete();
    g_ch.delete(); g_cyc.delete();
    l_pop = 0; r_pop = 0;
    xm[0] = 0; xm[1] = 0; ym[0] = 0; ym[1] = 0;
    refresh();
  endtask

  task automatic do_reset(input bit release_rst);
    reset = 1'b1; l_full = 1'b0; r_full = 1'b0; clear = 1'b0;
    clear_logs();
    step(2);
    if (release_rst) begin
      reset = 1'b0;
      step(1);
    end
  endtask

  task automatic push_l(input int x);
    lq.push_back(x);
    exp_l.push_back(model_step(0, x));
    refresh();
  endtask

  task automatic push_r(input int x);
    rq.push_back(x);
    exp_r.push_back(model_step(1, x));
    refresh();
  endtask

  task automatic wait_outs(input int nl, input int nr, input int budget, output bit ok);
    int k = 0;
    while ((got_l.size() < nl || got_r.size() < nr) && k < budget) begin
      step(1);
      k++;
    end
    ok = (got_l.size() >= nl && got_r.size() >= nr);
  endtask

  task automatic wait_grant(input int n, input int budget, output bit ok);
    int k = 0;
    while (g_ch.size() < n && k < budget) begin
      step(1);
      k++;
    end
    ok = (g_ch.size() >= n);
  endtask

  task automatic test_reset();
    bit ok;
    do_reset(0);
    push_l(5);
    #1;
    tests++; if (l_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b want 0", l_rd_en); end
    tests++; if (l_wr_en !== 1'b0 || r_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b%b want 00", l_wr_en, r_wr_en); end
    tests++; if (l_dout !== 32'd0 || r_dout !== 32'd0) begin fails++; $display("FAIL reset_dout: got %h %h want 0", l_dout, r_dout); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    wait_outs(1, 0, 40, ok);
    tests++; if (!ok || got_l[0] !== exp_l[0]) begin fails++; $display("FAIL reset_first_out: ok=%0b got %0d want %0d", ok, ok ? got_l[0] : 0, exp_l[0]); end
  endtask

  task automatic test_impulse();
    bit ok;
    int want[3] = '{178, 293, 190};
    do_reset(1);
    push_l(1024); push_l(0); push_l(0);
    wait_outs(3, 0, 100, ok);
    step(10);
    tests++; if (!ok) begin fails++; $display("FAIL impulse_timeout: got %0d outputs want 3", got_l.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= got_l.size() || got_l[i] !== want[i]) begin
        fails++; $display("FAIL impulse_val%0d: got %0d want %0d", i, (i < got_l.size()) ? got_l[i] : 0, want[i]);
      end
      tests++;
      if (i >= got_l.size() || i >= g_cyc.size() || got_l_cyc[i] - g_cyc[i] !== 5) begin
        fails++; $display("FAIL impulse_latency%0d: got %0d want 5", i, (i < got_l.size() && i < g_cyc.size()) ? got_l_cyc[i] - g_cyc[i] : -1);
      end
    end
    tests++; if (got_r.size() !== 0) begin fails++; $display("FAIL impulse_r_wr: got %0d writes want 0", got_r.size()); end
  endtask

  task automatic test_sign();
    bit ok;
    do_reset(1);
    push_l(-1024);
    wait_outs(1, 0, 40, ok);
    tests++; if (!ok || got_l[0] !== -178) begin fails++; $display("FAIL sign_neg1024: got %0d want -178", ok ? got_l[0] : 0); end
    do_reset(1);
    push_l(-1018);
    wait_outs(1, 0, 40, ok);
    tests++; if (!ok || got_l[0] !== exp_l[0]) begin fails++; $display("FAIL sign_neg1018: got %0d want %0d", ok ? got_l[0] : 0, exp_l[0]); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      push_l(int'($urandom()));
      push_r(int'($urandom()));
    end
    reset = 1'b0;
    wait_outs(3, 3, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rr_timeout: got %0d/%0d want 3/3", got_l.size(), got_r.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= g_ch.size() || g_ch[i] !== (i % 2)) begin
        fails++; $display("FAIL rr_order%0d: got %0d want %0d", i, (i < g_ch.size()) ? g_ch[i] : -1, i % 2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= got_l.size() || got_l[i] !== exp_l[i]) begin
        fails++; $display("FAIL rr_l%0d: got %0d want %0d", i, (i < got_l.size()) ? got_l[i] : 0, exp_l[i]);
      end
      tests++;
      if (i >= got_r.size() || got_r[i] !== exp_r[i]) begin
        fails++; $display("FAIL rr_r%0d: got %0d want %0d", i, (i < got_r.size()) ? got_r[i] : 0, exp_r[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset(1);
    l_full = 1'b1;
    push_l(int'($urandom_range(0, 100000)));
    push_r(int'($urandom_range(0, 100000)));
    step(20);
    tests++; if (g_ch.size() !== 1 || g_ch[0] !== 1) begin fails++; $display("FAIL bp_grants: got %0d grants want 1 (R)", g_ch.size()); end
    tests++; if (got_r.size() !== 1 || got_r[0] !== exp_r[0]) begin fails++; $display("FAIL bp_r_out: got %0d outs want 1 value %0d", got_r.size(), exp_r[0]); end
    tests++; if (got_l.size() !== 0) begin fails++; $display("FAIL bp_l_blocked: got %0d outs want 0", got_l.size()); end
    l_full = 1'b0;
    wait_outs(1, 1, 40, ok);
    tests++; if (!ok || got_l[0] !== exp_l[0]) begin fails++; $display("FAIL bp_l_release: got %0d want %0d", ok ? got_l[0] : 0, exp_l[0]); end

    do_reset(1);
    push_l(int'($urandom()));
    wait_grant(1, 40, ok);
    step(1);
    l_full = 1'b1;
    step(10);
    tests++; if (!ok || busy !== 1'b1) begin fails++; $display("FAIL bp_hold_busy: got %b want 1", busy); end
    tests++; if (got_l.size() !== 0) begin fails++; $display("FAIL bp_hold_nowr: got %0d writes want 0", got_l.size()); end
    l_full = 1'b0;
    step(10);
    tests++; if (got_l.size() !== 1 || got_l[0] !== exp_l[0]) begin fails++; $display("FAIL bp_hold_release: got %0d writes want 1 value %0d", got_l.size(), exp_l[0]); end
  endtask

  task automatic test_clear();
    bit ok;
    do_reset(1);
    push_l(1024);
    wait_grant(1, 40, ok);
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    xm[0] = 0; ym[0] = 0;
    wait_outs(1, 0, 40, ok);
    tests++; if (!ok || got_l[0] !== 178) begin fails++; $display("FAIL clr_mid_out: got %0d want 178", ok ? got_l[0] : 0); end
    push_l(0);
    wait_outs(2, 0, 40, ok);
    tests++; if (!ok || got_l[1] !== 0) begin fails++; $display("FAIL clr_mid_next: got %0d want 0", ok ? got_l[1] : -1); end

    do_reset(1);
    push_l(int'($urandom()));
    wait_outs(1, 0, 40, ok);
    clear = 1'b1;
    step(1);
    xm[0] = 0; ym[0] = 0; xm[1] = 0; ym[1] = 0;
    push_l(int'($urandom()));
    push_r(int'($urandom()));
    @(negedge clock);
    #1;
    tests++; if (l_rd_en !== 1'b0 || r_rd_en !== 1'b0) begin fails++; $display("FAIL clr_idle_rd: got %b%b want 00", l_rd_en, r_rd_en); end
    step(1);
    clear = 1'b0;
    wait_outs(2, 1, 60, ok);
    tests++; if (!ok || got_l[1] !== exp_l[1]) begin fails++; $display("FAIL clr_idle_l: got %0d want %0d", ok ? got_l[1] : 0, exp_l[1]); end
    tests++; if (!ok || got_r[0] !== exp_r[0]) begin fails++; $display("FAIL clr_idle_r: got %0d want %0d", ok ? got_r[0] : 0, exp_r[0]); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset(1);
    push_l(int'($urandom_range(1000, 900000)));
    wait_outs(1, 0, 40, ok);
    lq.push_back(int'($urandom()));
    refresh();
    wait_grant(2, 40, ok);
    step(2);
    reset = 1'b1;
    #1;
    tests++; if (!ok || l_dout !== 32'd0 || l_wr_en !== 1'b0) begin fails++; $display("FAIL arst_outputs: got %h/%b want 0/0", l_dout, l_wr_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_busy: got %b want 0", busy); end
    clear_logs();
    step(2);
    push_r(int'($urandom()));
    push_l(int'($urandom()));
    reset = 1'b0;
    wait_outs(1, 1, 60, ok);
    tests++; if (g_ch.size() < 1 || g_ch[0] !== 0) begin fails++; $display("FAIL arst_first_grant: got %0d want 0", (g_ch.size() > 0) ? g_ch[0] : -1); end
    tests++; if (!ok || got_l[0] !== exp_l[0] || got_r[0] !== exp_r[0]) begin fails++; $display("FAIL arst_history: got %0d/%0d want %0d/%0d", ok ? got_l[0] : 0, ok ? got_r[0] : 0, exp_l[0], exp_r[0]); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_sign();
    test_round_robin();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
